lifo_stack_host: RTL
====================

// Module: lifo_stack_host
// PURPOSE
//  Initiator side of the two-phase push/pop stack protocol. Accepts byte-wide
//  push/pop commands on a valid/ready port and drives stk_push/stk_pop/stk_wdata
//  phase-aligned to the stack's internal step toggle. Returns pop data and
//  overflow/underflow errors on a one-cycle response strobe. Sits between the
//  host logic (pins or a sequencer) and the LIFO stack macro.
// PARAMETERS
//  DATA_W  8    stack word width
//  DEPTH   256  stack entries; must match the stack macro (power of 2)
//  CNT_W   9    depth counter width, $clog2(DEPTH)+1
// PORTS
//  clk        in   1       clock
//  rst_n      in   1       reset, asynchronous, active-low
//  cmd_valid  in   1       command present
//  cmd_ready  out  1       command accepted when cmd_valid & cmd_ready
//  cmd_op     in   1       0 = push, 1 = pop
//  cmd_data   in   DATA_W  push data (ignored for pop)
//  resp_valid out  1       one-cycle response strobe, no back-pressure
//  resp_data  out  DATA_W  popped word (0 for push or error)
//  resp_err   out  1       1 = push when full / pop when empty, no stack op done
//  stk_push   out  1       to stack push, registered
//  stk_pop    out  1       to stack pop, registered
//  stk_wdata  out  DATA_W  to stack write data, registered
//  stk_rdata  in   DATA_W  from stack registered read output
//  depth      out  CNT_W   current entry count, 0..DEPTH
//  full/empty out  1       depth==DEPTH / depth==0
// BEHAVIOUR
//  Reset: all outputs 0 except empty=1; state IDLE; phase=0; depth=0.
//  phase: 1-bit toggle, 0 after reset, inverts every clk, mirrors stack step.
//  FSM IDLE->OP0->OP1->{CAPT->RESP | RESP}->IDLE; ERR path IDLE->RESP.
//  cmd_ready = (state==IDLE) & (phase==1); accept only then. An op therefore
//   always starts on phase 0.
//  Accept valid op in cycle N: stk_push or stk_pop = 1 and stk_wdata = cmd_data
//   during N+1 (phase 0, OP0) and N+2 (phase 1, OP1); deasserted from N+3.
//  Push: resp_valid=1, resp_err=0, resp_data=0 in N+3; depth+1 at end of N+2.
//  Pop: stk_rdata sampled at end of N+3 (CAPT); resp_valid, resp_data in N+4;
//   depth-1 at end of N+2.
//  Error (push & full or pop & empty): no stk_* activity; resp_valid=1,
//   resp_err=1, resp_data=0 in N+1; depth unchanged.
//  resp_valid never asserted two consecutive cycles; next accept is at the
//   first phase==1 cycle in IDLE after the response.
//  Never both stk_push and stk_pop high; stk_* change only at OP0 entry/OP1 exit.
//  depth saturates by rule: never exceeds DEPTH, never below 0 (errors block).
//  Reset mid-operation: all state cleared async; stack macro is reset
//   by the same rst_n so pointers and phase stay aligned.
//  cmd_data/cmd_op are only sampled at accept; changes elsewhere are ignored.
// TESTING
//  Reset, hold cmd_valid=0 -> cmd_ready toggles 0/1 with phase, empty=1, depth=0.
//  Push 0xA5 then pop -> stk_push high 2 cycles from phase 0; pop resp_data=0xA5,
//   resp_err=0, resp_valid 4 cycles after accept; depth 0->1->0.
//  Push 0x01,0x02,0x03 then 3 pops -> resp_data 0x03,0x02,0x01 (LIFO order).
//  Pop at depth 0 -> resp_err=1 next cycle, stk_pop never asserted, depth=0.
//  Push DEPTH words (i&0xFF) -> full=1; extra push -> resp_err=1; pop -> 0xFF.
//  Assert rst_n=0 during OP1 of a push -> all outputs 0 immediately, depth=0;
//   after release push 0x5A/pop -> 0x5A.

Source files
------------

// File: rtl/lifo_stack_host.sv
// lifo_stack_host: initiator side of the two-phase push/pop stack protocol.
// Takes push/pop commands on a valid/ready port and drives the stack macro's
// push/pop/wdata strobes aligned to its internal step toggle. Each command
// returns exactly one response strobe carrying pop data or an error flag.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   command handshake (ready only in IDLE on phase 1)
//   cmd_op, cmd_data      0 = push / 1 = pop, push data
//   resp_valid            one-cycle response strobe
//   resp_data, resp_err   popped word, push-when-full / pop-when-empty flag
//   stk_push, stk_pop     registered stack strobes, high for two cycles
//   stk_wdata             registered stack write data
//   stk_rdata             stack registered read output
//   depth, full, empty    entry count and its boundary flags
module lifo_stack_host #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_op,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_err,
    output logic              stk_push,
    output logic              stk_pop,
    output logic [DATA_W-1:0] stk_wdata,
    input  logic [DATA_W-1:0] stk_rdata,
    output logic [CNT_W-1:0]  depth,
    output logic              full,
    output logic              empty
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        OP0  = 3'd1,
        OP1  = 3'd2,
        CAPT = 3'd3,
        RESP = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic                phase_q;
    logic                op_q, op_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic                resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0]   resp_data_q, resp_data_d;
    logic                resp_err_q, resp_err_d;
    logic                stk_push_q, stk_push_d;
    logic                stk_pop_q, stk_pop_d;
    logic [DATA_W-1:0]   stk_wdata_q, stk_wdata_d;
    logic [CNT_W-1:0]    depth_q, depth_d;
    logic                full_q, full_d;
    logic                empty_q, empty_d;
    logic                accept;
    logic                bad_op;

    // Accept is only possible when cmd_ready is high (IDLE, phase 1).
    assign accept = cmd_valid & cmd_ready_q;
    assign bad_op = cmd_op ? empty_q : full_q;

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            phase_q      <= 1'b0;
            op_q         <= 1'b0;
            cmd_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
            stk_push_q   <= 1'b0;
            stk_pop_q    <= 1'b0;
            stk_wdata_q  <= '0;
            depth_q      <= '0;
            full_q       <= 1'b0;
            empty_q      <= 1'b1;
        end else begin
            state_q      <= state_d;
            phase_q      <= ~phase_q;
            op_q         <= op_d;
            cmd_ready_q  <= cmd_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_err_q   <= resp_err_d;
            stk_push_q   <= stk_push_d;
            stk_pop_q    <= stk_pop_d;
            stk_wdata_q  <= stk_wdata_d;
            depth_q      <= depth_d;
            full_q       <= full_d;
            empty_q      <= empty_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        resp_valid_d = 1'b0;
        resp_data_d  = '0;
        resp_err_d   = 1'b0;
        stk_push_d   = stk_push_q;
        stk_pop_d    = stk_pop_q;
        stk_wdata_d  = stk_wdata_q;
        depth_d      = depth_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (bad_op) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else begin
                        state_d     = OP0;
                        op_d        = cmd_op;
                        stk_push_d  = ~cmd_op;
                        stk_pop_d   = cmd_op;
                        stk_wdata_d = cmd_data;
                    end
                end
            end
            OP0: begin
                state_d = OP1;
            end
            OP1: begin
                // Stack steps at the end of this phase-1 cycle.
                stk_push_d  = 1'b0;
                stk_pop_d   = 1'b0;
                stk_wdata_d = '0;
                if (op_q) begin
                    depth_d = depth_q - CNT_W'(1);
                    state_d = CAPT;
                end else begin
                    depth_d      = depth_q + CNT_W'(1);
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                end
            end
            CAPT: begin
                // Stack read register is valid one cycle after its step.
                state_d      = RESP;
                resp_valid_d = 1'b1;
                resp_data_d  = stk_rdata;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Flags follow the next-cycle state and phase so they stay registered.
    assign cmd_ready_d = (state_d == IDLE) & ~phase_q;
    assign full_d      = (depth_d == CNT_W'(DEPTH));
    assign empty_d     = (depth_d == '0);

    assign cmd_ready  = cmd_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_err   = resp_err_q;
    assign stk_push   = stk_push_q;
    assign stk_pop    = stk_pop_q;
    assign stk_wdata  = stk_wdata_q;
    assign depth      = depth_q;
    assign full       = full_q;
    assign empty      = empty_q;

endmodule
